pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the fp_adder integer carry adder.
- Splits a WIDTH-bit add/subtract into WIDTH/SEG segments; one segment is resolved per pipeline stage, and the carry is registered between stages.
- Sustains one operation per cycle with valid/ready flow control.
- Sits between the mantissa alignment logic and the normaliser in the FP datapath.

---
 rtl/pipelined_adder.sv | 188 ++++++++++++++++++
 tb/tb_pipelined_adder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit add/subtract split into STAGES = WIDTH/SEG segments. Each pipeline
//   stage resolves one SEG-bit segment with a carry-lookahead adder built from
//   4-bit groups. The segment carry-out is registered before the next stage uses
//   it, so no carry path crosses a register boundary combinationally.
//   Flow control: valid/ready. A stalled output freezes the whole pipe, bubbles
//   included. Latency is STAGES cycles and throughput is one operation per cycle.
//   Optional feature: define PIPELINED_ADDER_OVERFLOW_EN to add the signed
//   'overflow' output, which is computed in the last stage.
module pipelined_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int STAGES = WIDTH / SEG;
  localparam int GROUPS = SEG / 4;

  // Reject geometries that cannot be cut into whole segments of whole groups.
  if (((WIDTH % SEG) != 0) || ((SEG % 4) != 0) || (SEG < 4)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of SEG and SEG a multiple of 4");
  end

  // 4-bit carry-lookahead group: all internal carries come from generate/propagate
  // terms, with no ripple inside the group.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // SEG-bit segment adder: lookahead groups, group carries rippled in order.
  // Returns {carry_out, segment_sum}.
  function automatic logic [SEG:0] add_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] s;
    logic           c;
    logic [4:0]     r;
    s = '0;
    c = ci;
    for (int grp = 0; grp < GROUPS; grp++) begin
      r             = cla4(x[grp*4 +: 4], y[grp*4 +: 4], c);
      s[grp*4 +: 4] = r[3:0];
      c             = r[4];
    end
    return {c, s};
  endfunction

  // Stage inputs: the values that stage k consumes during this cycle.
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];

  // Stage results: the values that stage k registers.
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];

  // Stage registers.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;
`endif

  // Operand bits that have already been consumed still travel down the pipe.
  // They are collected here so that they read as deliberately left unconnected.
  logic [STAGES-1:0] unused_fold;
  logic              unused_ok;
  assign unused_ok = ^unused_fold;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0]     seg_r;
    logic [WIDTH-1:0] sum_k;

    if (k == 0) begin : g_head
      // Operand conditioning at accept: subtraction is A + ~B + 1.
      assign st_a[0] = a;
      assign st_b[0] = sub ? ~b : b;
      assign st_s[0] = '0;
      assign st_c[0] = sub ? 1'b1 : cin;
      assign st_v[0] = in_valid;
    end else begin : g_link
      assign st_a[k] = a_q[k-1];
      assign st_b[k] = b_q[k-1];
      assign st_s[k] = s_q[k-1];
      assign st_c[k] = c_q[k-1];
      assign st_v[k] = v_q[k-1];
    end

    assign seg_r = add_seg(st_a[k][k*SEG +: SEG], st_b[k][k*SEG +: SEG], st_c[k]);

    // Splice this stage's segment into the partial sum; other segments pass through.
    always_comb begin
      // NOTE: assigning the whole vector first means no path leaves it unassigned,
      // so no latch can be inferred.
      sum_k                = st_s[k];
      sum_k[k*SEG +: SEG]  = seg_r[SEG-1:0];
    end

    assign nxt_s[k]       = sum_k;
    assign nxt_c[k]       = seg_r[SEG];
    assign unused_fold[k] = ^{a_q[k], b_q[k]};

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    if (k == STAGES - 1) begin : g_ovf
      // Carry into the MSB is recovered as a ^ b_eff ^ sum at that bit.
      assign ovf_d = st_a[k][WIDTH-1] ^ st_b[k][WIDTH-1] ^ seg_r[SEG-1] ^ seg_r[SEG];
    end
`endif
  end

  // Pipeline registers: advance every stage together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are cleared too, not only the valid bits, so that
      // sum and carry read as 0 straight out of reset.
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else if (!stall) begin
      // NOTE: non-blocking assignments make every stage sample its predecessor's
      // value from before the edge, which is what makes this a shift pipeline.
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= st_v[k];
        a_q[k] <= st_a[k];
        b_q[k] <= st_b[k];
        s_q[k] <= nxt_s[k];
        c_q[k] <= nxt_c[k];
      end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry     = c_q[STAGES-1];
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Three instances of pipelined_adder: 64/16 (4 stages), 32/8 (4 stages) and
//   16/16 (1 stage). Directed cases with literal expectations run on the 64-bit
//   instance. Random traffic with random backpressure then runs on all three.
//   Every instance is compared on every cycle against a queue-based reference.
module tb_pipelined_adder;

  localparam int NCFG  = 3;
  localparam int NRAND = 10000;

  typedef struct packed {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_s  [NCFG];
  logic [63:0] a_s         [NCFG];
  logic [63:0] b_s         [NCFG];
  logic        cin_s       [NCFG];
  logic        sub_s       [NCFG];
  logic        out_ready_s [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  for (genvar i = 0; i < NCFG; i++) begin : g_cfg
    localparam int W   = (i == 0) ? 64 : (i == 1) ? 32 : 16;
    localparam int S   = (i == 1) ? 8 : 16;
    localparam int LAT = (i == 2) ? 1 : 4;   // required latency, written out by hand

    logic [W-1:0] sum_w;
    logic         carry_w;
    logic         out_valid_w;
    logic         in_ready_w;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic         ovf_w;
`endif

    pipelined_adder #(.WIDTH(W), .SEG(S)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid_s[i]),
      .in_ready (in_ready_w),
      .a        (a_s[i][W-1:0]),
      .b        (b_s[i][W-1:0]),
      .cin      (cin_s[i]),
      .sub      (sub_s[i]),
      .out_valid(out_valid_w),
      .out_ready(out_ready_s[i]),
      .sum      (sum_w),
      .carry    (carry_w)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ,
      .overflow (ovf_w)
`endif
    );

    // Reference: results in acceptance order. age = un-stalled edges since accept.
    // A result is due at the output once its age reaches LAT.
    exp_t exp_q [$];
    int   age_q [$];
    int   n_acc = 0;

    // Reference update on every clock edge.
    always @(posedge clk) begin
      logic         ev;
      logic         st;
      logic [W-1:0] aw;
      logic [W-1:0] bw;
      logic [W-1:0] rw;
      logic [W:0]   full;
      logic [W:0]   cw;
      exp_t         e;
      if (rst) begin
        exp_q.delete();
        age_q.delete();
      end else begin
        ev = (age_q.size() > 0) && (age_q[0] == LAT);
        st = ev && !out_ready_s[i];
        if (!st) begin
          if (ev) begin
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
          end
          for (int j = 0; j < age_q.size(); j++) age_q[j] = age_q[j] + 1;
          if (in_valid_s[i]) begin
            aw = a_s[i][W-1:0];
            bw = b_s[i][W-1:0];
            if (sub_s[i]) begin
              rw      = aw - bw;
              e.carry = (aw >= bw);
              e.ovf   = (aw[W-1] != bw[W-1]) && (rw[W-1] != aw[W-1]);
            end else begin
              cw      = '0;
              cw[0]   = cin_s[i];
              full    = {1'b0, aw} + {1'b0, bw} + cw;
              rw      = full[W-1:0];
              e.carry = full[W];
              e.ovf   = (aw[W-1] == bw[W-1]) && (rw[W-1] != aw[W-1]);
            end
            e.sum = 64'(rw);
            exp_q.push_back(e);
            age_q.push_back(1);
            n_acc++;
          end
        end
      end
    end

    // Compare the DUT against the reference on every cycle, away from the edge.
    always @(negedge clk) begin
      logic ev;
      ev = (age_q.size() > 0) && (age_q[0] == LAT);
      check($sformatf("cfg%0d out_valid", i), 64'(out_valid_w), 64'(ev));
      check($sformatf("cfg%0d in_ready", i), 64'(in_ready_w), 64'(!(ev && !out_ready_s[i])));
      if (ev) begin
        check($sformatf("cfg%0d sum", i), 64'(sum_w), exp_q[0].sum);
        check($sformatf("cfg%0d carry", i), 64'(carry_w), 64'(exp_q[0].carry));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        check($sformatf("cfg%0d overflow", i), 64'(ovf_w), 64'(exp_q[0].ovf));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(input logic [63:0] aa, input logic [63:0] bb, input logic c, input logic s);
    in_valid_s[0] = 1'b1;
    a_s[0]        = aa;
    b_s[0]        = bb;
    cin_s[0]      = c;
    sub_s[0]      = s;
  endtask

  // Steps until instance 0 shows out_valid. lat counts cycles since the last accept edge.
  task automatic wait_valid0(output int lat);
    lat = 1;
    while (!g_cfg[0].out_valid_w && lat < 20) begin
      step();
      lat++;
    end
  endtask

  function automatic int cfg_w(input int i);
    return (i == 0) ? 64 : (i == 1) ? 32 : 16;
  endfunction

  function automatic int cur_acc(input int i);
    case (i)
      0:       return g_cfg[0].n_acc;
      1:       return g_cfg[1].n_acc;
      default: return g_cfg[2].n_acc;
    endcase
  endfunction

  // Operands biased toward carry and overflow corner values.
  function automatic logic [63:0] rnd_val(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      2:       v = 64'd1 << (w - 1);
      3:       v = ~(64'd1 << (w - 1));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] bb_exp [4];
    int          lat;
    int          start_acc [NCFG];
    int          cyc;
    logic        done;

    rst = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      in_valid_s[i]  = 1'b0;
      a_s[i]         = '0;
      b_s[i]         = '0;
      cin_s[i]       = 1'b0;
      sub_s[i]       = 1'b0;
      out_ready_s[i] = 1'b1;
    end
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("reset in_ready", 64'(g_cfg[0].in_ready_w), 64'd1);
    check("reset out_valid", 64'(g_cfg[0].out_valid_w), 64'd0);
    check("reset sum", g_cfg[0].sum_w, 64'd0);
    check("reset carry", 64'(g_cfg[0].carry_w), 64'd0);

    // Carry rippling through all four segment registers.
    op0('1, 64'd1, 1'b0, 1'b0);
    step();
    in_valid_s[0] = 1'b0;
    wait_valid0(lat);
    check("full carry latency", 64'(lat), 64'd4);
    check("full carry sum", g_cfg[0].sum_w, 64'd0);
    check("full carry carry", 64'(g_cfg[0].carry_w), 64'd1);
    step();

    // Back-to-back operations: results arrive on consecutive cycles.
    bb_exp = '{64'd3, 64'd7, 64'h0000_0000_0001_0000, 64'h8000_0000_0000_0000};
    op0(64'd1, 64'd2, 1'b0, 1'b0);                    step();
    op0(64'd3, 64'd4, 1'b0, 1'b0);                    step();
    op0(64'h0000_FFFF, 64'd1, 1'b0, 1'b0);            step();
    op0(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);  step();
    in_valid_s[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b%0d valid", k), 64'(g_cfg[0].out_valid_w), 64'd1);
      check($sformatf("b2b%0d sum", k), g_cfg[0].sum_w, bb_exp[k]);
      check($sformatf("b2b%0d carry", k), 64'(g_cfg[0].carry_w), 64'd0);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      check($sformatf("b2b%0d overflow", k), 64'(g_cfg[0].ovf_w), 64'(k == 3));
`endif
      step();
    end
    check("b2b drained", 64'(g_cfg[0].out_valid_w), 64'd0);

    // Subtraction, with and without a borrow. cin is ignored when sub=1.
    op0(64'd5, 64'd7, 1'b1, 1'b1); step();
    op0(64'd7, 64'd5, 1'b0, 1'b1); step();
    in_valid_s[0] = 1'b0;
    wait_valid0(lat);
    check("sub 5-7 sum", g_cfg[0].sum_w, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub 5-7 carry", 64'(g_cfg[0].carry_w), 64'd0);
    step();
    check("sub 7-5 sum", g_cfg[0].sum_w, 64'd2);
    check("sub 7-5 carry", 64'(g_cfg[0].carry_w), 64'd1);
    step();

    // Backpressure with three operations in flight.
    out_ready_s[0] = 1'b0;
    op0(64'd100, 64'd200, 1'b0, 1'b0);   step();
    op0('1, '1, 1'b1, 1'b0);             step();
    op0(64'h123, 64'h23, 1'b0, 1'b1);    step();
    in_valid_s[0] = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check("stall in_ready", 64'(g_cfg[0].in_ready_w), 64'd0);
      check("stall valid", 64'(g_cfg[0].out_valid_w), 64'd1);
      check("stall sum", g_cfg[0].sum_w, 64'd300);
      op0(64'hDEAD, 64'hBEEF, 1'b0, 1'b0);  // must not be captured while stalled
      step();
    end
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    check("release r0 sum", g_cfg[0].sum_w, 64'd300);
    check("release r0 carry", 64'(g_cfg[0].carry_w), 64'd0);
    step();
    check("release r1 sum", g_cfg[0].sum_w, 64'hFFFF_FFFF_FFFF_FFFF);
    check("release r1 carry", 64'(g_cfg[0].carry_w), 64'd1);
    step();
    check("release r2 sum", g_cfg[0].sum_w, 64'h100);
    check("release r2 carry", 64'(g_cfg[0].carry_w), 64'd1);
    step();
    check("release drained", 64'(g_cfg[0].out_valid_w), 64'd0);

    // Reset with two operations in flight.
    op0(64'd11, 64'd22, 1'b0, 1'b0); step();
    op0(64'd33, 64'd44, 1'b0, 1'b0); step();
    in_valid_s[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post-reset in_ready", 64'(g_cfg[0].in_ready_w), 64'd1);
    for (int k = 0; k < 6; k++) begin
      check("flushed valid", 64'(g_cfg[0].out_valid_w), 64'd0);
      step();
    end
    op0(64'd1000, 64'd1, 1'b0, 1'b0);
    step();
    in_valid_s[0] = 1'b0;
    wait_valid0(lat);
    check("post-reset latency", 64'(lat), 64'd4);
    check("post-reset sum", g_cfg[0].sum_w, 64'd1001);
    step();

    // Random traffic with random backpressure on all three geometries.
    for (int i = 0; i < NCFG; i++) start_acc[i] = cur_acc(i);
    cyc  = 0;
    done = 1'b0;
    while (cyc < 60000 && !done) begin
      for (int i = 0; i < NCFG; i++) begin
        in_valid_s[i]  = (cur_acc(i) < start_acc[i] + NRAND) && ($urandom_range(0, 9) < 7);
        a_s[i]         = rnd_val(cfg_w(i));
        b_s[i]         = rnd_val(cfg_w(i));
        cin_s[i]       = 1'(($urandom & 1) != 0);
        sub_s[i]       = 1'(($urandom & 1) != 0);
        out_ready_s[i] = ($urandom_range(0, 3) != 0);
      end
      step();
      cyc++;
      done = 1'b1;
      for (int i = 0; i < NCFG; i++)
        if (cur_acc(i) < start_acc[i] + NRAND) done = 1'b0;
    end
    check("random traffic within cycle budget", 64'(done), 64'd1);

    for (int i = 0; i < NCFG; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b1;
    end
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
